// File: rtl/axis_upsizer_n.sv
// AXI-Stream width upsizer: packs N W-bit beats into one W*N-bit word,
// first beat in the top slot, with tlast-driven partial flush and per-slot tkeep.
module axis_upsizer_n #(
  parameter int W = 40,
  parameter int N = 4
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [W-1:0]   in_tdata,
  input  logic           in_tvalid,
  input  logic           in_tlast,
  output logic           in_tready,
  output logic [W*N-1:0] out_tdata,
  output logic [N-1:0]   out_tkeep,
  output logic           out_tlast,
  output logic           out_tvalid,
  input  logic           out_tready
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [CW-1:0]  r_cnt;
  logic [W*N-1:0] r_out_data;
  logic [N-1:0]   r_out_keep;
  logic           r_out_last;
  logic           r_out_valid;

  logic           w_accept;
  logic           w_complete;
  logic [CW-1:0]  w_slot;
  logic [W*N-1:0] w_word_data;
  logic [N-1:0]   w_word_keep;

  // Ready only looks at the output register, so a completing beat can always retire.
  assign in_tready  = ~areset & (~r_out_valid | out_tready);
  assign w_accept   = in_tvalid & in_tready;
  assign w_complete = w_accept & (in_tlast | (r_cnt == LAST_CNT));
  assign w_slot     = LAST_CNT - r_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      if (gi == 0) begin : g_low
        // The lowest slot is only ever filled by a completing beat.
        logic w_hit;
        assign w_hit             = (w_slot == CW'(gi));
        assign w_word_data[W-1:0] = w_hit ? in_tdata : '0;
        assign w_word_keep[0]     = w_hit;
      end else begin : g_acc
        logic         w_hit;
        logic [W-1:0] r_data;
        logic         r_keep;

        assign w_hit = (w_slot == CW'(gi));
        // Stale data behind a cleared keep bit is masked to zero.
        assign w_word_data[gi*W +: W] = w_hit ? in_tdata : (r_keep ? r_data : '0);
        assign w_word_keep[gi]        = w_hit | r_keep;

        always_ff @(posedge aclk) begin
          if (w_accept && !w_complete && w_hit) begin
            r_data <= in_tdata;
          end
        end

        always_ff @(posedge aclk or posedge areset) begin
          if (areset) begin
            r_keep <= 1'b0;
          end else if (w_complete) begin
            r_keep <= 1'b0;
          end else if (w_accept && w_hit) begin
            r_keep <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt <= '0;
    end else if (w_complete) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_word_data;
      r_out_keep  <= w_word_keep;
      r_out_last  <= in_tlast;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_tdata  = r_out_data;
  assign out_tkeep  = r_out_keep;
  assign out_tlast  = r_out_last;
  assign out_tvalid = r_out_valid;

endmodule

// File: tb/tb_axis_upsizer_n.sv
// Randomised and directed bench for axis_upsizer_n (N=4 main instance, N=2 regression instance).
module tb_axis_upsizer_n;
  localparam int W = 40;
  localparam int N = 4;

  logic           aclk = 1'b0;
  logic           areset = 1'b0;
  logic [W-1:0]   in_tdata = '0;
  logic           in_tvalid = 1'b0;
  logic           in_tlast = 1'b0;
  logic           in_tready;
  logic [W*N-1:0] out_tdata;
  logic [N-1:0]   out_tkeep;
  logic           out_tlast;
  logic           out_tvalid;
  logic           out_tready = 1'b0;

  logic [W-1:0]   d2_in_tdata = '0;
  logic           d2_in_tvalid = 1'b0;
  logic           d2_in_tlast = 1'b0;
  logic           d2_in_tready;
  logic [2*W-1:0] d2_out_tdata;
  logic [1:0]     d2_out_tkeep;
  logic           d2_out_tlast;
  logic           d2_out_tvalid;
  logic           d2_out_tready = 1'b1;

  axis_upsizer_n #(.W(W), .N(N)) dut (
    .aclk(aclk), .areset(areset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  axis_upsizer_n #(.W(W), .N(2)) dut2 (
    .aclk(aclk), .areset(areset),
    .in_tdata(d2_in_tdata), .in_tvalid(d2_in_tvalid), .in_tlast(d2_in_tlast), .in_tready(d2_in_tready),
    .out_tdata(d2_out_tdata), .out_tkeep(d2_out_tkeep), .out_tlast(d2_out_tlast),
    .out_tvalid(d2_out_tvalid), .out_tready(d2_out_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W*N-1:0] d;
    logic [N-1:0]   k;
    logic           l;
    int             c;
  } word_t;

  word_t        exp_q[$];
  word_t        got_q[$];
  word_t        got2[$];
  logic [W-1:0] part[$];
  int           acc_cyc[$];
  int           acc2[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           mode = 0;
  int           ph = 0;

  task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Output backpressure patterns, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      ph++;
      case (mode)
        0: out_tready = 1'b1;
        1: out_tready = ((ph % 16) >= 8);
        2: out_tready = ph[0];
        3: out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  // Monitor + reference model: words are rebuilt from accepted beats by slot rule.
  logic           prev_stall = 1'b0;
  logic [W*N-1:0] prev_d;
  logic [N-1:0]   prev_k;
  logic           prev_l;
  always @(negedge aclk) begin
    word_t e;
    word_t g;
    cyc++;
    if (areset) begin
      part.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", out_tdata, prev_d);
        chk("stall_keep", out_tkeep, prev_k);
        chk("stall_last", out_tlast, prev_l);
        chk("stall_valid", out_tvalid, 1'b1);
      end
      if (out_tvalid && !out_tready) chk("stall_in_tready", in_tready, 1'b0);
      if (out_tvalid && out_tready) begin
        chk("exp_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_data", out_tdata, e.d);
          chk("sb_keep", out_tkeep, e.k);
          chk("sb_last", out_tlast, e.l);
        end
        g.d = out_tdata; g.k = out_tkeep; g.l = out_tlast; g.c = cyc;
        got_q.push_back(g);
      end
      if (in_tvalid && in_tready) begin
        part.push_back(in_tdata);
        acc_cyc.push_back(cyc);
        if (in_tlast || part.size() == N) begin
          e.d = '0; e.k = '0; e.l = in_tlast; e.c = 0;
          for (int k = 0; k < part.size(); k++) begin
            e.d[(N-1-k)*W +: W] = part[k];
            e.k[N-1-k] = 1'b1;
          end
          exp_q.push_back(e);
          part.delete();
        end
      end
      prev_stall = out_tvalid & ~out_tready;
      prev_d = out_tdata; prev_k = out_tkeep; prev_l = out_tlast;
      if (d2_in_tvalid && d2_in_tready) acc2.push_back(cyc);
      if (d2_out_tvalid && d2_out_tready) begin
        g.d = '0; g.d[2*W-1:0] = d2_out_tdata; g.k = '0; g.k[1:0] = d2_out_tkeep;
        g.l = d2_out_tlast; g.c = cyc;
        got2.push_back(g);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    int t = 0;
    in_tdata = d; in_tlast = l; in_tvalid = 1'b1;
    @(negedge aclk);
    while (!in_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("send_ready", in_tready, 1'b1);
    @(posedge aclk);
    #1;
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic send2(input logic [W-1:0] d);
    int t = 0;
    d2_in_tdata = d; d2_in_tlast = 1'b0; d2_in_tvalid = 1'b1;
    @(negedge aclk);
    while (!d2_in_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    chk("send2_ready", d2_in_tready, 1'b1);
    @(posedge aclk);
    #1;
    d2_in_tvalid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(negedge aclk);
      t++;
    end
    chk("words_seen", got_q.size(), n);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_tvalid) && t < 500) begin
      @(negedge aclk);
      t++;
    end
    chk("drain_done", exp_q.size(), 0);
    idle(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_tvalid, 1'b0);
    chk({tag, "_data"}, out_tdata, '0);
    chk({tag, "_keep"}, out_tkeep, '0);
    chk({tag, "_last"}, out_tlast, 1'b0);
    chk({tag, "_in_tready"}, in_tready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  logic [W-1:0]   b2b [8];
  logic [W*N-1:0] tmp;
  logic [2*W-1:0] w2 [3];
  logic [W-1:0]   f [4];
  int             bp_before;

  initial begin
    b2b = '{"ABCDE", "FGHIJ", "KLMON", "PQRST", "UVWXY", "Zabcd", "efghi", "jklmn"};
    w2  = '{"ABCDEFGHIJ", "KLMONPQRST", "UVWXYZabcd"};

    // Power-up reset, asserted off the clock edge.
    #2 areset = 1'b1;
    #1 chk_reset_outputs("init_rst");
    repeat (3) @(posedge aclk);
    #3 areset = 1'b0;
    mode = 0;
    idle(2);

    // Back-to-back full words.
    got_q.delete(); acc_cyc.delete();
    for (int i = 0; i < 8; i++) send(b2b[i], 1'b0);
    wait_words(2, 50);
    if (got_q.size() >= 2 && acc_cyc.size() >= 8) begin
      tmp = "ABCDEFGHIJKLMONPQRST";
      chk("b2b_w0_data", got_q[0].d, tmp);
      chk("b2b_w0_keep", got_q[0].k, 4'b1111);
      chk("b2b_w0_last", got_q[0].l, 1'b0);
      chk("b2b_w0_cycle", got_q[0].c, acc_cyc[3] + 1);
      tmp = "UVWXYZabcdefghijklmn";
      chk("b2b_w1_data", got_q[1].d, tmp);
      chk("b2b_w1_keep", got_q[1].k, 4'b1111);
      chk("b2b_w1_last", got_q[1].l, 1'b0);
      chk("b2b_w1_cycle", got_q[1].c, acc_cyc[7] + 1);
    end
    idle(3);
    chk("b2b_word_count", got_q.size(), 2);

    // Partial flush followed by a single-beat packet starting again at the top slot.
    got_q.delete();
    send("ABCDE", 1'b0);
    send("FGHIJ", 1'b1);
    send("ABCDE", 1'b1);
    wait_words(2, 50);
    if (got_q.size() >= 2) begin
      tmp = '0; tmp[159:80] = "ABCDEFGHIJ";
      chk("flush_data", got_q[0].d, tmp);
      chk("flush_keep", got_q[0].k, 4'b1100);
      chk("flush_last", got_q[0].l, 1'b1);
      tmp = '0; tmp[159:120] = "ABCDE";
      chk("single_data", got_q[1].d, tmp);
      chk("single_keep", got_q[1].k, 4'b1000);
      chk("single_last", got_q[1].l, 1'b1);
    end
    drain();

    // Backpressure patterns, 3 x 8 beats with random input gaps each.
    for (int m = 1; m <= 3; m++) begin
      mode = m;
      got_q.delete();
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < 8; i++) begin
          idle($urandom_range(0, 2));
          send({$urandom(), 8'($urandom())}, 1'b0);
        end
      end
      drain();
      bp_before = got_q.size();
      chk("bp_word_count", bp_before, 6);
    end

    // Random packets with random tlast under random backpressure.
    mode = 3;
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 1));
      send({$urandom(), 8'($urandom())}, (i == 29) || ($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset while a completed word is stalled at the output.
    mode = 4;
    idle(2);
    got_q.delete();
    for (int i = 0; i < 4; i++) send({$urandom(), 8'($urandom())}, 1'b0);
    idle(2);
    chk("pre_rst_valid", out_tvalid, 1'b1);
    @(negedge aclk);
    #2 areset = 1'b1;
    #1 chk_reset_outputs("stall_rst");
    repeat (3) @(posedge aclk);
    #3 areset = 1'b0;
    mode = 0;
    idle(3);
    chk("rst_dropped_word", got_q.size(), 0);

    // Reset mid-word: the partial beats must not leak into the next word.
    send("xxxxx", 1'b0);
    send("yyyyy", 1'b0);
    #2 areset = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    repeat (3) @(posedge aclk);
    #3 areset = 1'b0;
    idle(1);
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      f[i] = {$urandom(), 8'($urandom())};
      send(f[i], 1'b0);
    end
    wait_words(1, 50);
    if (got_q.size() >= 1) begin
      tmp = {f[0], f[1], f[2], f[3]};
      chk("fresh_data", got_q[0].d, tmp);
      chk("fresh_keep", got_q[0].k, 4'b1111);
    end
    drain();

    // N=2 regression on the second instance.
    acc2.delete(); got2.delete();
    for (int i = 0; i < 6; i++) send2(b2b[i]);
    begin
      int t = 0;
      while (got2.size() < 3 && t < 1000) begin
        @(negedge aclk);
        t++;
      end
    end
    chk("n2_word_count", got2.size(), 3);
    if (got2.size() >= 3 && acc2.size() >= 6) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("n2_w%0d_data", i), got2[i].d, {80'b0, w2[i]});
        chk($sformatf("n2_w%0d_keep", i), got2[i].k, 4'b0011);
        chk($sformatf("n2_w%0d_cycle", i), got2[i].c, acc2[2*i+1] + 1);
      end
    end

    idle(2);
    chk("sb_empty", exp_q.size(), 0);
    chk("partial_empty", part.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_upsizer_n.md
# axis_upsizer_n

Parametrised AXI-Stream width upsizer that packs N consecutive W-bit input beats into one W*N-bit output word. It generalises the fixed 2:1 upsizer with an arbitrary ratio, `tlast`-driven partial-word flush and a per-slot `tkeep`. It sits between a narrow stream producer and a wide datapath consumer. It is a drop-in successor when N=2 and `in_tlast` is tied low.

## Interface
Parameters:
- `W`, 40: input beat width in bits; W >= 1.
- `N`, 4: packing ratio (input beats per output word); N >= 2.

Ports:
- `aclk`  in  1: clock; all state changes on the rising edge.
- `areset`  in  1: asynchronous, active-high reset.
- `in_tdata`  in  W: input beat.
- `in_tvalid`  in  1: input beat valid.
- `in_tlast`  in  1: last beat of a packet; forces a flush of the current word.
- `in_tready`  out  1: block accepts an input beat this cycle.
- `out_tdata`  out  W*N: packed output word.
- `out_tkeep`  out  N: one bit per W-bit slot; 1 = slot holds a valid beat.
- `out_tlast`  out  1: word ends a packet.
- `out_tvalid`  out  1: output word valid.
- `out_tready`  in  1: consumer accepts the output word.

## Operation
- Slot order: the first beat of a word goes to slot N-1, the most significant bits `[W*N-1 : W*(N-1)]`. Beat k of the word goes to slot N-1-k. This matches the 2:1 upsizer, which puts the first beat in the upper half.
- State:
  - accumulator: W*(N-1) data bits, N-1 keep bits, and slot counter `cnt` (0..N-1, width $clog2(N)).
  - output register: `out_tdata`, `out_tkeep`, `out_tlast`, `out_tvalid`.
- Input accept: `accept = in_tvalid & in_tready`.
- `in_tready = ~areset & (~out_tvalid | out_tready)`. This is a combinational path from `out_tready`. It guarantees that every accepted beat, including a completing beat, can be retired the same cycle.
- On accept with `cnt < N-1` and `in_tlast = 0`:
  - store the beat in slot N-1-cnt;
  - set that keep bit;
  - `cnt <= cnt + 1`.
- On accept with `cnt == N-1`, or with `in_tlast = 1` (word completion):
  - load the output register with the accumulator plus the current beat in slot N-1-cnt;
  - `out_tkeep` = accumulator keep plus the current slot bit;
  - unfilled slots are driven to 0 in both `out_tdata` and `out_tkeep`;
  - `out_tlast <= in_tlast`;
  - `out_tvalid <= 1`;
  - clear `cnt` and the accumulator keep bits.
- Output drain: if `out_tvalid & out_tready` and no completion occurs this cycle, `out_tvalid <= 0`. Completion and drain in the same cycle means the new word replaces the old one and `out_tvalid` stays 1.
- While `out_tvalid & ~out_tready`: the output register holds all values stable and `in_tready = 0`. The accumulator is frozen.
- `in_tlast` on the very first beat (`cnt = 0`) emits a word with `out_tkeep = 1` in slot N-1 only.
- There is no zero-length flush: a `tlast` can only arrive with a beat.

## Timing
- Reset values while `areset` is high, applied immediately (asynchronously):
  - `out_tvalid = 0`, `out_tdata = 0`, `out_tkeep = 0`, `out_tlast = 0`;
  - `cnt = 0`, accumulator keep = 0;
  - `in_tready = 0`.
- Reset mid-word discards partial data. Reset with `out_tvalid = 1` drops the pending word without a handshake.
- Latency: `out_tvalid` rises on the first rising edge after the completing beat is accepted (1 cycle).
- Throughput: with `out_tready` held at 1, one beat is accepted per cycle and one word is produced every N cycles, with no bubbles across words.
- Handshake: `out_tvalid` never deasserts without a transfer. `out_tdata`, `out_tkeep` and `out_tlast` are stable while `out_tvalid & ~out_tready`.
- `in_tready` does not depend on `in_tvalid`, `in_tdata` or `in_tlast`.

## Test plan
All scenarios use W=40, N=4 unless stated. A scoreboard queue checks every output word against the accepted beats, and must be empty at end of test.
- Back-to-back, `out_tready = 1`: input "ABCDE","FGHIJ","KLMON","PQRST","UVWXY","Zabcd","efghi","jklmn".
  - Required: "ABCDEFGHIJKLMONPQRST" then "UVWXYZabcdefghijklmn".
  - Both words have `out_tkeep = 4'b1111` and `out_tlast = 0`.
  - Each `out_tvalid` pulse is 1 cycle, the cycle after beats 4 and 8.
- Partial flush: "ABCDE", then "FGHIJ" with `in_tlast = 1`.
  - Required: upper 80 bits = "ABCDEFGHIJ", lower 80 bits = 0.
  - `out_tkeep = 4'b1100`, `out_tlast = 1`.
  - The next word starts again at slot 3.
- Single-beat packet: "ABCDE" with `tlast = 1` at `cnt = 0`.
  - Required: `out_tkeep = 4'b1000`, `out_tlast = 1`, lower 120 bits = 0.
- Backpressure (run each stall pattern below against 3 repetitions of 8 beats with `in_tvalid` gaps):
  - `out_tready` 0 for 8 cycles;
  - `out_tready` alternating 0/1 each cycle;
  - `out_tready` random each cycle.
  - Required: `in_tready = 0` whenever `out_tvalid & ~out_tready`; outputs stable while stalled.
  - Required: no loss or duplication; the scoreboard matches all 6 words.
- Reset mid-word: accept 2 beats, pulse `areset` asynchronously off the clock edge for 3 cycles, then send 4 fresh beats.
  - Required: outputs go to 0 immediately; `in_tready = 0` during reset.
  - Required: the first output word contains only the 4 fresh beats.
- N=2 regression with `in_tlast = 0`, replaying the 6-beat back-to-back sequence.
  - Required: "ABCDEFGHIJ", "KLMONPQRST", "UVWXYZabcd", each with `tkeep = 2'b11`.
  - Same cycle timing as the original 2:1 upsizer.
  - No hang within 1000 cycles.
